// File: rtl/warships_pkg.sv
// rtl/warships_pkg.sv - shared link types, grid constants and coordinate helper
package warships_pkg;

   localparam int GRID_SIZE_DEF = 12;
   localparam int LINK_BITS     = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD,
      ST_WAIT_LOW
   } link_state_t;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
   } cords_t;

   function automatic logic cords_in_grid(input cords_t c, input int grid);
      return (int'(c.x) < grid) && (int'(c.y) < grid);
   endfunction

endpackage

// File: rtl/link_sync.sv
// rtl/link_sync.sv - multi-stage flop synchroniser for asynchronous peer-board pins
module link_sync #(
   parameter int WIDTH       = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_chain [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_chain[i] <= '0;
         end
      end else begin
         r_chain[0] <= i_d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_chain[i] <= r_chain[i-1];
         end
      end
   end

   assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/board_link_rx.sv
// rtl/board_link_rx.sv - peer-board coordinate receiver: synchronise, debounce, range-check, four-phase handshake
module board_link_rx
   import warships_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int GRID_SIZE     = GRID_SIZE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ready_in,
   input  logic       hit_in,
   input  logic [7:0] cords_in,
   input  logic       ack,
   output logic [7:0] cords_out,
   output logic       hit_out,
   output logic       cords_valid,
   output logic       cords_err,
   output logic       peer_ready
);

   localparam int                CNT_W    = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [LINK_BITS-1:0] w_sync;
   logic                 w_ready_s;
   logic                 w_hit_s;
   cords_t               w_cords_s;

   link_state_t          r_state;
   link_state_t          w_state_nxt;
   cords_t               r_shadow;
   cords_t               w_shadow_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 w_capture_ok;
   logic                 w_capture_bad;

   logic [7:0]           r_cords_out;
   logic                 r_hit_out;
   logic                 r_err;

   link_sync #(
      .WIDTH       (LINK_BITS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d ({ready_in, hit_in, cords_in}),
      .o_q (w_sync)
   );

   assign w_ready_s = w_sync[9];
   assign w_hit_s   = w_sync[8];
   assign w_cords_s = cords_t'(w_sync[7:0]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_shadow <= '0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   // cnt only advances while below CNT_LAST; the capture exit leaves SETTLE before it could wrap
   always_comb begin
      w_state_nxt   = r_state;
      w_shadow_nxt  = r_shadow;
      w_cnt_nxt     = r_cnt;
      w_capture_ok  = 1'b0;
      w_capture_bad = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ready_s) begin
               w_state_nxt  = ST_SETTLE;
               w_shadow_nxt = w_cords_s;
               w_cnt_nxt    = '0;
            end
         end
         ST_SETTLE: begin
            if (!w_ready_s) begin
               w_state_nxt = ST_IDLE;
            end else if (w_cords_s != r_shadow) begin
               w_shadow_nxt = w_cords_s;
               w_cnt_nxt    = '0;
            end else if (r_cnt == CNT_LAST) begin
               if (cords_in_grid(r_shadow, GRID_SIZE)) begin
                  w_capture_ok = 1'b1;
                  w_state_nxt  = ST_HOLD;
               end else begin
                  w_capture_bad = 1'b1;
                  w_state_nxt   = ST_WAIT_LOW;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_HOLD: begin
            if (ack) begin
               w_state_nxt = ST_WAIT_LOW;
            end
         end
         ST_WAIT_LOW: begin
            if (!w_ready_s) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cords_out <= 8'h00;
         r_hit_out   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err <= w_capture_bad;
         if (w_capture_ok) begin
            r_cords_out <= r_shadow;
            r_hit_out   <= w_hit_s;
         end
      end
   end

   assign cords_out   = r_cords_out;
   assign hit_out     = r_hit_out;
   assign cords_err   = r_err;
   assign cords_valid = (r_state == ST_HOLD);
   assign peer_ready  = w_ready_s;

endmodule

// File: tb/tb_board_link_rx.sv
// tb/tb_board_link_rx.sv - directed scenarios plus randomized traffic against a transaction-level model
module tb_board_link_rx;

   localparam int SS   = 2;
   localparam int ST   = 4;
   localparam int GRID = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ready_in = 1'b0;
   logic       hit_in = 1'b0;
   logic [7:0] cords_in = 8'h00;
   logic       ack = 1'b0;
   logic [7:0] cords_out;
   logic       hit_out;
   logic       cords_valid;
   logic       cords_err;
   logic       peer_ready;

   int n_checks = 0;
   int n_pass   = 0;

   board_link_rx #(
      .SYNC_STAGES   (SS),
      .STABLE_CYCLES (ST),
      .GRID_SIZE     (GRID)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ready_in    (ready_in),
      .hit_in      (hit_in),
      .cords_in    (cords_in),
      .ack         (ack),
      .cords_out   (cords_out),
      .hit_out     (hit_out),
      .cords_valid (cords_valid),
      .cords_err   (cords_err),
      .peer_ready  (peer_ready)
   );

   always #5 clk = ~clk;

   task automatic record(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      record(name, {7'd0, act}, {7'd0, exp});
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      record(name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: pins reach the receiver SS edges late; a word is taken once ST+1 identical
   // samples have been seen in one unbroken ready-high window, and re-arming needs ready low.
   int         ms = 0;        // 0 waiting, 1 collecting, 2 offering, 3 awaiting ready low
   logic [7:0] hist[$];
   bit         mp_r[SS];
   bit         mp_h[SS];
   logic [7:0] mp_c[SS];
   logic [7:0] m_cords = 8'h00;
   bit         m_hit = 1'b0;
   bit         m_err = 1'b0;
   bit         m_valid = 1'b0;
   bit         m_peer = 1'b0;

   function automatic int run_len();
      int n = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] == hist[hist.size()-1]) n++;
         else break;
      end
      return n;
   endfunction

   task automatic model_reset();
      ms = 0;
      hist.delete();
      for (int i = 0; i < SS; i++) begin
         mp_r[i] = 1'b0;
         mp_h[i] = 1'b0;
         mp_c[i] = 8'h00;
      end
      m_cords = 8'h00;
      m_hit   = 1'b0;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_peer  = 1'b0;
   endtask

   task automatic model_step();
      bit         rs;
      bit         hs;
      logic [7:0] cs;
      rs = mp_r[SS-1];
      hs = mp_h[SS-1];
      cs = mp_c[SS-1];
      m_err = 1'b0;
      case (ms)
         0: if (rs) begin
               hist.delete();
               hist.push_back(cs);
               ms = 1;
            end
         1: if (!rs) ms = 0;
            else begin
               hist.push_back(cs);
               if (run_len() >= ST + 1) begin
                  if (int'(cs[7:4]) < GRID && int'(cs[3:0]) < GRID) begin
                     m_cords = cs;
                     m_hit   = hs;
                     ms      = 2;
                  end else begin
                     m_err = 1'b1;
                     ms    = 3;
                  end
               end
            end
         2: if (ack) ms = 3;
         default: if (!rs) ms = 0;
      endcase
      for (int i = SS - 1; i > 0; i--) begin
         mp_r[i] = mp_r[i-1];
         mp_h[i] = mp_h[i-1];
         mp_c[i] = mp_c[i-1];
      end
      mp_r[0] = ready_in;
      mp_h[0] = hit_in;
      mp_c[0] = cords_in;
      m_valid = (ms == 2);
      m_peer  = mp_r[SS-1];
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk1("cmp_valid", cords_valid, m_valid);
         chk8("cmp_cords", cords_out, m_cords);
         chk1("cmp_hit", hit_out, m_hit);
         chk1("cmp_err", cords_err, m_err);
         chk1("cmp_peer", peer_ready, m_peer);
      end
   end

   initial begin
      int cnt;
      cyc(3);
      #1;
      chk1("reset_valid", cords_valid, 1'b0);
      chk8("reset_cords", cords_out, 8'h00);
      chk1("reset_peer", peer_ready, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      cyc(3);

      // Scenario 1: latency and indefinite hold
      cords_in = 8'h35; hit_in = 1'b1; ready_in = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk1("s1_edge6_valid", cords_valid, 1'b0);
      @(posedge clk);
      #1 chk1("s1_edge7_valid", cords_valid, 1'b1);
      chk8("s1_cords", cords_out, 8'h35);
      chk1("s1_hit", hit_out, 1'b1);
      cyc(20);
      chk1("s1_held", cords_valid, 1'b1);

      // Scenario 2: ack, no re-capture while ready stays high, then new word
      ack = 1'b1;
      @(posedge clk);
      #1 chk1("s2_ack_fall", cords_valid, 1'b0);
      @(negedge clk);
      ack = 1'b0;
      cyc(50);
      chk1("s2_no_recapture", cords_valid, 1'b0);
      ready_in = 1'b0;
      cyc(5);
      cords_in = 8'h4A; hit_in = 1'b0; ready_in = 1'b1;
      cyc(10);
      chk1("s2_valid2", cords_valid, 1'b1);
      chk8("s2_cords2", cords_out, 8'h4A);
      chk1("s2_hit2", hit_out, 1'b0);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0; ready_in = 1'b0;
      cyc(5);

      // Scenario 3: toggling coordinates never settle
      ready_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cords_in = (i % 2 == 1) ? 8'h13 : 8'h12;
         cyc(3);
      end
      chk1("s3_no_capture", cords_valid, 1'b0);
      cyc(12);
      chk1("s3_valid", cords_valid, 1'b1);
      chk8("s3_cords", cords_out, 8'h13);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0; ready_in = 1'b0;
      cyc(5);

      // Scenario 4: out-of-range x
      cords_in = 8'hC2; ready_in = 1'b1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1 if (cords_err) cnt++;
      end
      chk8("s4_err_pulses", 8'(cnt), 8'd1);
      chk1("s4_valid", cords_valid, 1'b0);
      chk8("s4_cords_kept", cords_out, 8'h13);
      @(negedge clk);
      ready_in = 1'b0;
      cyc(5);

      // Scenario 5: short ready pulse, then ready drop during offer
      cords_in = 8'h56; hit_in = 1'b1; ready_in = 1'b1;
      cyc(3);
      ready_in = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1 if (cords_valid) cnt++;
      end
      chk8("s5_pulse_no_valid", 8'(cnt), 8'd0);
      @(negedge clk);
      ready_in = 1'b1;
      cyc(10);
      chk1("s5_valid", cords_valid, 1'b1);
      ready_in = 1'b0;
      cyc(10);
      chk1("s5_kept_valid", cords_valid, 1'b1);
      chk8("s5_kept_cords", cords_out, 8'h56);
      ack = 1'b1;
      @(posedge clk);
      #1 chk1("s5_ack_fall", cords_valid, 1'b0);
      @(negedge clk);
      ack = 1'b0;
      cyc(3);

      // Scenario 6: reset during offer, fresh capture after release
      cords_in = 8'h21; hit_in = 1'b0; ready_in = 1'b1;
      cyc(10);
      chk1("s6_pre_valid", cords_valid, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk1("s6_rst_valid", cords_valid, 1'b0);
      chk8("s6_rst_cords", cords_out, 8'h00);
      chk1("s6_rst_hit", hit_out, 1'b0);
      chk1("s6_rst_peer", peer_ready, 1'b0);
      cords_in = 8'h07;
      cyc(2);
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk1("s6_edge6_valid", cords_valid, 1'b0);
      @(posedge clk);
      #1 chk1("s6_edge7_valid", cords_valid, 1'b1);
      chk8("s6_cords", cords_out, 8'h07);
      @(negedge clk);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0; ready_in = 1'b0;
      cyc(4);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) ready_in = ~ready_in;
         if ($urandom_range(0, 5) == 0) begin
            cords_in = 8'($urandom);
            hit_in   = 1'($urandom);
         end
         ack = ($urandom_range(0, 3) == 0);
         cyc(1);
      end
      ack = 1'b0;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
